wb_crypto_regbank: RTL and testbench

WB_CRYPTO_REGBANK -- requirements
Module: wb_crypto_regbank

---
 rtl/wb_crypto_regbank.sv | 175 +++++++++++++++++
 tb/tb_wb_crypto_regbank.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_crypto_regbank.sv
// Wishbone classic register bank fronting a crypto core: operand registers, CTRL/STATUS,
// result capture, start/done handshake with the core and a level interrupt.
module wb_crypto_regbank #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int unsigned NUM_WREGS    = 8,
    parameter int unsigned NUM_RREGS    = 4
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [32*NUM_WREGS-1:0] regs_o,
    output logic                    start_o,
    input  logic                    done_i,
    input  logic [32*NUM_RREGS-1:0] result_i,
    output logic                    irq_o,
    output logic                    dbg_state_o
);

    localparam int unsigned CTRL_IDX = NUM_WREGS;
    localparam int unsigned STAT_IDX = NUM_WREGS + 1;
    localparam int unsigned RES_BASE = NUM_WREGS + 2;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] wreg_q [NUM_WREGS];
    logic [31:0] wreg_d [NUM_WREGS];
    logic [31:0] rreg_q [NUM_RREGS];
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        start_q;
    logic        irq_q;

    logic        valid, fire, wr_fire, rd_fire;
    logic [31:0] offset, word_idx;
    logic        aligned, hit_op, hit_ctrl, hit_stat;
    logic        op_wr, ctrl_wr, stat_wr, start_req;
    logic        busy, start_ok, start_bad, capture;
    logic [31:0] rdata;

    // Handshake: valid = cyc & stb; an access fires when valid is seen with ack low, and
    // ack follows one cycle later for exactly one cycle, so side-effects happen once per access.
    assign valid   = wbs_cyc_i & wbs_stb_i;
    assign fire    = valid & ~ack_q;
    assign wr_fire = fire & wbs_we_i;
    assign rd_fire = fire & ~wbs_we_i;

    // Addresses below the base wrap to huge offsets and therefore decode as unmapped.
    assign offset   = wbs_adr_i - BASE_ADDRESS;
    assign aligned  = (offset[1:0] == 2'b00);
    assign word_idx = {2'b00, offset[31:2]};
    assign hit_op   = aligned && (word_idx < NUM_WREGS);
    assign hit_ctrl = aligned && (word_idx == CTRL_IDX);
    assign hit_stat = aligned && (word_idx == STAT_IDX);

    assign ctrl_wr   = wr_fire & hit_ctrl & wbs_sel_i[0];
    assign stat_wr   = wr_fire & hit_stat & wbs_sel_i[0];
    assign start_req = ctrl_wr & wbs_dat_i[0];

    // FSM state register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_req) state_d = S_RUN;
            S_RUN:   if (done_i)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state_q == S_RUN);
        start_ok  = start_req & ~busy;
        start_bad = start_req & busy;
        capture   = busy & done_i;
        op_wr     = wr_fire & hit_op & ~busy;
    end

    // Sticky status: a set in the same cycle as a write-1-to-clear wins.
    always_comb begin
        irq_en_d = ctrl_wr ? wbs_dat_i[1] : irq_en_q;
        done_d   = done_q;
        err_d    = err_q;
        if (stat_wr && wbs_dat_i[1]) done_d = 1'b0;
        if (stat_wr && wbs_dat_i[2]) err_d  = 1'b0;
        if (start_ok)                done_d = 1'b0;
        if (capture)                 done_d = 1'b1;
        if (start_bad)               err_d  = 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_WREGS; i++) begin
            wreg_d[i] = wreg_q[i];
            if (op_wr && (word_idx == 32'(i))) begin
                for (int b = 0; b < 4; b++) begin
                    if (wbs_sel_i[b]) wreg_d[i][8*b +: 8] = wbs_dat_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (aligned) begin
            for (int i = 0; i < NUM_WREGS; i++) begin
                if (word_idx == 32'(i)) rdata = wreg_q[i];
            end
            if (word_idx == CTRL_IDX) rdata = {30'h0, irq_en_q, 1'b0};
            if (word_idx == STAT_IDX) rdata = {29'h0, err_q, done_q, busy};
            for (int j = 0; j < NUM_RREGS; j++) begin
                if (word_idx == RES_BASE + 32'(j)) rdata = rreg_q[j];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            start_q  <= 1'b0;
            irq_q    <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_WREGS; i++) wreg_q[i] <= 32'h0;
            for (int j = 0; j < NUM_RREGS; j++) rreg_q[j] <= 32'h0;
        end else begin
            ack_q    <= fire;
            dat_q    <= rd_fire ? rdata : 32'h0;
            start_q  <= start_ok;
            // Built from the registered bits, so irq falls one cycle after its cause clears.
            irq_q    <= irq_en_q & (done_q | err_q);
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            for (int i = 0; i < NUM_WREGS; i++) wreg_q[i] <= wreg_d[i];
            if (capture) begin
                for (int j = 0; j < NUM_RREGS; j++) rreg_q[j] <= result_i[32*j +: 32];
            end
        end
    end

    for (genvar g = 0; g < NUM_WREGS; g++) begin : g_regs
        assign regs_o[32*g +: 32] = wreg_q[g];
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign start_o     = start_q;
    assign irq_o       = irq_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_crypto_regbank.sv
// Directed bench for wb_crypto_regbank: Wishbone accesses, start/done handshake,
// sticky status, interrupt timing and asynchronous reset behaviour.
module tb_wb_crypto_regbank;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h20;
    localparam logic [31:0] A_STAT = BASE + 32'h24;
    localparam logic [31:0] A_RES0 = BASE + 32'h28;
    localparam logic [31:0] A_RES1 = BASE + 32'h2C;

    logic          clk = 1'b0;
    logic          rst;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, wdat;
    logic          ack;
    logic [31:0]   rdat;
    logic [255:0]  regs;
    logic          start;
    logic          done;
    logic [127:0]  result;
    logic          irq;
    logic          dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;
    int start_cnt    = 0;

    logic [31:0] rd;
    int          s0;

    wb_crypto_regbank dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (rdat),
        .regs_o      (regs),
        .start_o     (start),
        .done_i      (done),
        .result_i    (result),
        .irq_o       (irq),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Counts cycles with start_o high, sampled away from the rising edge.
    always @(negedge clk) if (start) start_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One Wishbone access; every access must ack exactly one cycle after valid.
    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [31:0] data);
        int lat;
        lat = 0;
        data = 32'h0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                lat = n;
                break;
            end
        end
        data = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("ack_latency", lat, 1);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] unused;
        wb_access(1'b1, a, d, s, unused);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        wb_access(1'b0, a, 32'h0, 4'hF, d);
    endtask

    task automatic pulse_done(input logic [31:0] r0, input logic [31:0] r1);
        @(posedge clk); #1;
        done = 1'b1;
        result[31:0]  = r0;
        result[63:32] = r1;
        @(posedge clk); #1;
        done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; wdat = 32'h0; done = 1'b0; result = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, ack}, 0);
        check("rst_dat", rdat, 0);
        check("rst_start", {31'h0, start}, 0);
        check("rst_irq", {31'h0, irq}, 0);
        check("rst_regs_any", {31'h0, |regs}, 0);
        check("rst_state", {31'h0, dbg_state}, 0);
        rst = 1'b0;

        // Byte-lane write to operand 0, with explicit ack timing
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; wdat = 32'hDEADBEEF; sel = 4'b0101;
        check("op0_ack_before", {31'h0, ack}, 0);
        @(posedge clk); #1;
        check("op0_ack_one_cycle", {31'h0, ack}, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("op0_ack_width", {31'h0, ack}, 0);
        check("op0_regs", regs[31:0], 32'h00AD00EF);

        wb_write(BASE + 32'h4, 32'h11223344, 4'h0);
        check("op1_sel0", regs[63:32], 32'h0);
        wb_write(BASE + 32'h4, 32'h11223344, 4'hF);
        check("op1_regs", regs[63:32], 32'h11223344);
        wb_read(BASE + 32'h4, rd);
        check("op1_read", rd, 32'h11223344);
        wb_read(BASE, rd);
        check("op0_read", rd, 32'h00AD00EF);

        // Start with IRQ_EN, complete after a few cycles
        s0 = start_cnt;
        wb_write(A_CTRL, 32'h3, 4'hF);
        check("run_state", {31'h0, dbg_state}, 1);
        wb_read(A_STAT, rd);
        check("stat_busy", rd, 32'h1);
        wb_read(A_CTRL, rd);
        check("ctrl_read", rd, 32'h2);
        repeat (2) @(posedge clk);
        pulse_done(32'h12345678, 32'hA5A5A5A5);
        @(posedge clk); #1;
        check("start_pulses_1", start_cnt - s0, 1);
        check("irq_after_done", {31'h0, irq}, 1);
        wb_read(A_STAT, rd);
        check("stat_done", rd, 32'h2);
        wb_read(A_RES0, rd);
        check("res0", rd, 32'h12345678);
        wb_read(A_RES1, rd);
        check("res1", rd, 32'hA5A5A5A5);

        // Restart clears DONE; START during RUN flags ERR; operands frozen in RUN
        s0 = start_cnt;
        wb_write(A_CTRL, 32'h3, 4'hF);
        wb_read(A_STAT, rd);
        check("stat_restart", rd, 32'h1);
        wb_write(A_CTRL, 32'h3, 4'hF);
        repeat (2) @(posedge clk);
        check("start_pulses_2", start_cnt - s0, 1);
        wb_read(A_STAT, rd);
        check("stat_err", rd, 32'h5);
        wb_write(BASE + 32'hC, 32'hCAFEF00D, 4'hF);
        wb_read(BASE + 32'hC, rd);
        check("op3_run_ignored", rd, 32'h0);
        pulse_done(32'h0BADCAFE, 32'h0);
        wb_read(A_STAT, rd);
        check("stat_done_err", rd, 32'h6);
        check("irq_done_err", {31'h0, irq}, 1);
        wb_write(A_STAT, 32'h6, 4'hF);
        @(posedge clk); #1;
        check("irq_drop", {31'h0, irq}, 0);
        wb_read(A_STAT, rd);
        check("stat_cleared", rd, 32'h0);

        // Unmapped and misaligned accesses
        wb_read(BASE + 32'h100, rd);
        check("unmapped_read", rd, 32'h0);
        wb_read(BASE + 32'h2, rd);
        check("misaligned_read", rd, 32'h0);
        wb_read(BASE - 32'h4, rd);
        check("below_base_read", rd, 32'h0);
        wb_write(BASE + 32'h2, 32'hFFFFFFFF, 4'hF);
        check("misaligned_write", regs[31:0], 32'h00AD00EF);

        // done_i while idle changes nothing
        pulse_done(32'hFFFFFFFF, 32'hFFFFFFFF);
        wb_read(A_STAT, rd);
        check("idle_done_stat", rd, 32'h0);
        wb_read(A_RES0, rd);
        check("idle_done_res0", rd, 32'h0BADCAFE);

        // DONE set coincident with its W1C: set wins
        wb_write(A_CTRL, 32'h3, 4'hF);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_STAT; wdat = 32'h2; sel = 4'hF;
        done = 1'b1; result[31:0] = 32'h55AA55AA;
        @(posedge clk); #1;
        done = 1'b0;
        check("w1c_coincide_ack", {31'h0, ack}, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        wb_read(A_STAT, rd);
        check("w1c_coincide_stat", rd, 32'h2);
        wb_read(A_RES0, rd);
        check("w1c_coincide_res0", rd, 32'h55AA55AA);

        // Asynchronous reset mid-RUN with a read in flight
        wb_write(A_CTRL, 32'h3, 4'hF);
        check("pre_rst_state", {31'h0, dbg_state}, 1);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT; sel = 4'hF;
        #3 rst = 1'b1;
        #1;
        check("arst_ack", {31'h0, ack}, 0);
        check("arst_start", {31'h0, start}, 0);
        check("arst_irq", {31'h0, irq}, 0);
        check("arst_regs_any", {31'h0, |regs}, 0);
        check("arst_state", {31'h0, dbg_state}, 0);
        @(posedge clk); #1;
        check("arst_no_ack", {31'h0, ack}, 0);
        check("arst_dat", rdat, 0);
        cyc = 1'b0; stb = 1'b0;
        rst = 1'b0;
        pulse_done(32'h77777777, 32'h0);
        wb_read(A_STAT, rd);
        check("post_rst_stat", rd, 32'h0);
        wb_read(A_RES0, rd);
        check("post_rst_res0", rd, 32'h0);
        check("post_rst_irq", {31'h0, irq}, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
